// File: rtl/ldpc_bist_pkg.sv
// Shared types and default constants for the LDPC decoder BIST sequencer.
package ldpc_bist_pkg;

  localparam int N_DEF       = 256;
  localparam int FRAMES_DEF  = 100;
  localparam int TIMEOUT_DEF = 4096;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_FETCH = 3'd1;
  localparam state_t S_LATCH = 3'd2;
  localparam state_t S_ISSUE = 3'd3;
  localparam state_t S_WAIT  = 3'd4;
  localparam state_t S_CHECK = 3'd5;
  localparam state_t S_DONE  = 3'd6;

  // A single-frame run still needs a one-bit address bus.
  function automatic int addr_w(input int frames);
    return (frames > 1) ? $clog2(frames) : 1;
  endfunction

endpackage

// File: rtl/ldpc_bist_timer.sv
// Loadable down-counter guarding the decoder response; expire is high once the count reaches zero.
module ldpc_bist_timer
  import ldpc_bist_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] cnt;

  // Loading TIMEOUT-1 makes expire assert in the TIMEOUT-th enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TW'(TIMEOUT - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - TW'(1);
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/ldpc_bist_seq.sv
// Frame sequencer: streams test-memory words through the LDPC decoder and scores each result.
// Optional first-failure capture ports are enabled by defining LDPC_BIST_FAILCAP_EN.
module ldpc_bist_seq
  import ldpc_bist_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int FRAMES  = FRAMES_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int AW      = addr_w(FRAMES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   pass_cnt,
  output logic [AW:0]   fail_cnt,
  output logic          timeout_err,
  output logic [AW-1:0] mem_addr,
  input  logic [N-1:0]  mem_tx,
  input  logic [N-1:0]  mem_gt,
  output logic          dec_work,
  output logic [N-1:0]  dec_tx,
  input  logic          dec_free,
  input  logic [N-1:0]  dec_deout,
  input  logic          dec_valid
`ifdef LDPC_BIST_FAILCAP_EN
  ,
  output logic [AW-1:0] first_fail_idx,
  output logic [N-1:0]  first_fail_word,
  output logic          fail_seen
`endif
);

  localparam int            CW       = AW + 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(FRAMES - 1);

  state_t        state;
  logic [AW-1:0] idx;
  logic [N-1:0]  gt_q;
  logic [N-1:0]  deout_q;
  logic          tmr_expire;
  logic          accept;
  logic          last_frame;
  logic          timed_out;
  logic          match;
  state_t        step_state;
  logic [AW-1:0] step_idx;

  assign accept     = ((state == S_IDLE) || (state == S_DONE)) && start;
  assign last_frame = (idx == LAST_IDX);
  assign step_state = last_frame ? S_DONE : S_FETCH;
  assign step_idx   = last_frame ? idx : idx + AW'(1);
  // A valid in the expiry cycle takes priority, so the frame is still checked.
  assign timed_out  = (state == S_WAIT) && !dec_valid && tmr_expire;
  assign match      = (deout_q == gt_q);

  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign done     = (state == S_DONE);
  assign mem_addr = idx;
  assign dec_work = (state == S_ISSUE) && dec_free;

  ldpc_bist_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (dec_work),
    .en    (state == S_WAIT),
    .expire(tmr_expire)
  );

  // NOTE: sequential state uses <= so every register samples pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      timeout_err <= 1'b0;
      dec_tx      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state       <= S_FETCH;
            idx         <= '0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            timeout_err <= 1'b0;
          end
        end
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          dec_tx <= mem_tx;
          state  <= S_ISSUE;
        end
        S_ISSUE: begin
          if (dec_free) state <= S_WAIT;
        end
        S_WAIT: begin
          if (dec_valid) begin
            state <= S_CHECK;
          end else if (tmr_expire) begin
            fail_cnt    <= fail_cnt + CW'(1);
            timeout_err <= 1'b1;
            state       <= step_state;
            idx         <= step_idx;
          end
        end
        S_CHECK: begin
          if (match) pass_cnt <= pass_cnt + CW'(1);
          else       fail_cnt <= fail_cnt + CW'(1);
          state <= step_state;
          idx   <= step_idx;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: wide payload registers are left without reset; each is written before it is read.
  always_ff @(posedge clk) begin
    if (state == S_LATCH) gt_q <= mem_gt;
    if ((state == S_WAIT) && dec_valid) deout_q <= dec_deout;
  end

`ifdef LDPC_BIST_FAILCAP_EN
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      fail_seen       <= 1'b0;
      first_fail_idx  <= '0;
      first_fail_word <= '0;
    end else if (!fail_seen) begin
      if (timed_out) begin
        fail_seen       <= 1'b1;
        first_fail_idx  <= idx;
        first_fail_word <= '0;
      end else if ((state == S_CHECK) && !match) begin
        fail_seen       <= 1'b1;
        first_fail_idx  <= idx;
        first_fail_word <= deout_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ldpc_bist_seq.sv
// Self-checking bench for ldpc_bist_seq: synchronous test memory, fixed-latency echo decoder stub, scoreboard.
`timescale 1ns/1ps
module tb_ldpc_bist_seq;

  localparam int N       = 32;
  localparam int FRAMES  = 4;
  localparam int TIMEOUT = 16;
  localparam int L       = 5;
  localparam int AW      = 2;

  logic          clk_tb = 1'b0;
  logic          rst, start;
  logic          busy, done, timeout_err;
  logic [AW:0]   pass_cnt, fail_cnt;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_tx, mem_gt;
  logic          dec_work, dec_free, dec_valid;
  logic [N-1:0]  dec_tx, dec_deout;
`ifdef LDPC_BIST_FAILCAP_EN
  logic [AW-1:0] first_fail_idx;
  logic [N-1:0]  first_fail_word;
  logic          fail_seen;
`endif

  always #5 clk_tb = ~clk_tb;

  ldpc_bist_seq #(
    .N(N), .FRAMES(FRAMES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk_tb), .rst(rst), .start(start), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .timeout_err(timeout_err),
    .mem_addr(mem_addr), .mem_tx(mem_tx), .mem_gt(mem_gt),
    .dec_work(dec_work), .dec_tx(dec_tx), .dec_free(dec_free),
    .dec_deout(dec_deout), .dec_valid(dec_valid)
`ifdef LDPC_BIST_FAILCAP_EN
    , .first_fail_idx(first_fail_idx), .first_fail_word(first_fail_word), .fail_seen(fail_seen)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Synchronous test memory, one-cycle read latency.
  logic [N-1:0] tx_mem [FRAMES];
  logic [N-1:0] gt_mem [FRAMES];
  always @(posedge clk_tb) begin
    mem_tx <= tx_mem[mem_addr];
    mem_gt <= gt_mem[mem_addr];
  end

  // Decoder stub: echoes dec_tx with valid L cycles after the work pulse; hangs on frame hang_idx.
  logic         pend = 1'b0, stub_valid = 1'b0, spur_valid, free_en;
  logic [N-1:0] stub_word = '0;
  int           stub_cnt = 0;
  int           hang_idx;
  assign dec_free  = free_en & ~pend;
  assign dec_valid = stub_valid | spur_valid;
  assign dec_deout = stub_word;

  always @(posedge clk_tb) begin
    if (rst) begin
      pend       <= 1'b0;
      stub_valid <= 1'b0;
      stub_cnt   <= 0;
    end else begin
      stub_valid <= 1'b0;
      if (dec_work) begin
        if (int'(mem_addr) != hang_idx) begin
          pend      <= 1'b1;
          stub_cnt  <= 1;
          stub_word <= dec_tx;
        end
      end else if (pend) begin
        if (stub_cnt == L - 1) begin
          pend       <= 1'b0;
          stub_valid <= 1'b1;
        end
        stub_cnt <= stub_cnt + 1;
      end
    end
  end

  // Protocol monitors: work pulses never back-to-back, dec_tx stable while the decoder works.
  int   consec = 0, unstable = 0;
  logic prev_work = 1'b0;
  always begin
    @(negedge clk_tb);
    #2;
    if (dec_work && prev_work) consec++;
    prev_work = dec_work;
    if (pend && (dec_tx != stub_word)) unstable++;
  end

  typedef struct {
    logic         pass;
    logic         tmo;
    int           idx;
    logic [N-1:0] word;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   prev_pass = 0, prev_tot = 0, tot;
  logic ff_seen_tb = 1'b0;

  // Scoreboard: each completed frame pops the outcome predicted when its stimulus was loaded.
  always begin
    @(negedge clk_tb);
    #2;
    tot = int'(pass_cnt) + int'(fail_cnt);
    if (tot == prev_tot + 1) begin
      check("sb_nonempty", sb_q.size() > 0, 1'b1);
      if (sb_q.size() > 0) begin
        sb_e = sb_q.pop_front();
        check($sformatf("frame%0d_pass", sb_e.idx), int'(pass_cnt) != prev_pass, sb_e.pass);
        if (sb_e.tmo) check($sformatf("frame%0d_tmo", sb_e.idx), timeout_err, 1'b1);
`ifdef LDPC_BIST_FAILCAP_EN
        if (!sb_e.pass && !ff_seen_tb) begin
          ff_seen_tb = 1'b1;
          check("ff_seen", fail_seen, 1'b1);
          check("ff_idx", first_fail_idx, sb_e.idx);
          check("ff_word", first_fail_word, sb_e.word);
        end
`endif
      end
    end else if ((tot != prev_tot) && (tot != 0)) begin
      check("cnt_step", tot, prev_tot + 1);
    end
    prev_pass = int'(pass_cnt);
    prev_tot  = tot;
  end

  task automatic prep(input int flip_idx, input int hang, output int exp_cycles, output int exp_pass);
    exp_t e;
    hang_idx   = hang;
    exp_cycles = 1;
    exp_pass   = 0;
    ff_seen_tb = 1'b0;
    for (int i = 0; i < FRAMES; i++) begin
      tx_mem[i] = $urandom;
      gt_mem[i] = tx_mem[i];
      if (i == flip_idx) gt_mem[i][0] = ~gt_mem[i][0];
      e.pass = (i != flip_idx) && (i != hang);
      e.tmo  = (i == hang);
      e.idx  = i;
      e.word = (i == hang) ? '0 : tx_mem[i];
      sb_q.push_back(e);
      exp_cycles += (i == hang) ? (3 + TIMEOUT) : (L + 4);
      if (e.pass) exp_pass++;
    end
  endtask

  task automatic run(input int flip_idx, input int hang, input int hold, input bit extra_start);
    int n, works, first_work, exp_cycles, exp_pass;
    prep(flip_idx, hang, exp_cycles, exp_pass);
    exp_cycles += hold;
    @(negedge clk_tb);
    free_en = (hold == 0);
    start   = 1'b1;
    @(posedge clk_tb);
    @(negedge clk_tb);
    start      = 1'b0;
    n          = 1;
    works      = 0;
    first_work = 0;
    forever begin
      if (hold != 0) free_en = (n >= 3 + hold);
      start = extra_start && (n == 5);
      #1;
      if (n == 1) begin
        check("busy_on_start", busy, 1'b1);
        check("done_clr", done, 1'b0);
        check("pass_clr", pass_cnt, 0);
        check("fail_clr", fail_cnt, 0);
        check("tmo_clr", timeout_err, 1'b0);
      end
      if (dec_work) begin
        works++;
        if (works == 1) first_work = n;
      end
      if (done || (n >= 2000)) break;
      @(negedge clk_tb);
      n++;
    end
    start   = 1'b0;
    free_en = 1'b1;
    #2;
    check("done_cycles", n, exp_cycles);
    check("work_pulses", works, FRAMES);
    if (hold != 0) check("first_work", first_work, 3 + hold);
    check("pass_total", pass_cnt, exp_pass);
    check("fail_total", fail_cnt, FRAMES - exp_pass);
    check("tmo_final", timeout_err, hang >= 0);
    check("busy_done", busy, 1'b0);
    check("sb_drained", sb_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk_tb);
    rst        = 1'b1;
    start      = 1'b0;
    spur_valid = 1'b0;
    @(posedge clk_tb);
    @(posedge clk_tb);
    @(negedge clk_tb);
    rst = 1'b0;
    sb_q.delete();
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass_cnt, 0);
    check("rst_fail", fail_cnt, 0);
    check("rst_tmo", timeout_err, 1'b0);
    check("rst_addr", mem_addr, 0);
    check("rst_work", dec_work, 1'b0);
    check("rst_dec_tx", dec_tx, 0);
`ifdef LDPC_BIST_FAILCAP_EN
    check("rst_ff_seen", fail_seen, 1'b0);
    check("rst_ff_idx", first_fail_idx, 0);
    check("rst_ff_word", first_fail_word, 0);
`endif
  endtask

  task automatic spur_pulse();
    @(negedge clk_tb);
    spur_valid = 1'b1;
    repeat (3) @(negedge clk_tb);
    spur_valid = 1'b0;
    #1;
  endtask

  task automatic reset_mid_wait();
    int c, p, works, cyc;
    prep(-1, -1, c, p);
    @(negedge clk_tb);
    free_en = 1'b1;
    start   = 1'b1;
    @(posedge clk_tb);
    @(negedge clk_tb);
    start = 1'b0;
    works = 0;
    cyc   = 0;
    while ((works < 3) && (cyc < 500)) begin
      #1;
      if (dec_work) works++;
      @(negedge clk_tb);
      cyc++;
    end
    @(negedge clk_tb);
    check("rw_reached_f2", works, 3);
    check("rw_pass_before", pass_cnt, 2);
    check("rw_busy_before", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk_tb);
    @(negedge clk_tb);
    rst = 1'b0;
    sb_q.delete();
    #1;
    check("rw_busy", busy, 1'b0);
    check("rw_done", done, 1'b0);
    check("rw_pass", pass_cnt, 0);
    check("rw_fail", fail_cnt, 0);
    check("rw_work", dec_work, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    spur_valid = 1'b0;
    free_en    = 1'b1;
    hang_idx   = -1;
    for (int i = 0; i < FRAMES; i++) begin
      tx_mem[i] = '0;
      gt_mem[i] = '0;
    end

    do_reset();

    spur_pulse();
    check("spur_idle_busy", busy, 1'b0);
    check("spur_idle_pass", pass_cnt, 0);
    check("spur_idle_fail", fail_cnt, 0);

    run(-1, -1, 0, 1'b0);
    run(2, -1, 0, 1'b1);

    spur_pulse();
    check("spur_done_pass", pass_cnt, 3);
    check("spur_done_fail", fail_cnt, 1);
    check("spur_done_done", done, 1'b1);

    run(-1, 1, 0, 1'b0);
    run(-1, -1, 10, 1'b0);

    reset_mid_wait();
    run(-1, -1, 0, 1'b0);

    check("work_consec", consec, 0);
    check("dec_tx_stable", unstable, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
